// File: rtl/music_score_player.sv
// music_score_player: walks a score RAM of {key, duration} entries and
// presents each note to a tone generator for duration * BeatCycles cycles.
// Optional build macro SCORE_LOOP_EN: when defined, playback restarts from
// address 0 after the end of the score instead of returning to idle.
module music_score_player #(
    parameter int DataLength  = 4,
    parameter int AddressBits = 5,
    parameter int MemorySize  = 20,
    parameter int BeatCycles  = 25000000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Stop,
    input  logic [DataLength-1:0]  ScoreKey,
    input  logic [DataLength-1:0]  ScoreTime,
    output logic                   ReadOrWrite,
    output logic [AddressBits-1:0] Address,
    output logic [DataLength-1:0]  Key,
    output logic                   Playing,
    output logic                   Done
);

    localparam int PW = (BeatCycles > 1) ? $clog2(BeatCycles) : 1;
    localparam logic [PW-1:0]          PreLast  = PW'(BeatCycles - 1);
    localparam logic [PW-1:0]          PreOne   = PW'(1);
    localparam logic [AddressBits-1:0] LastAddr = AddressBits'(MemorySize - 1);
    localparam logic [AddressBits-1:0] AddrOne  = AddressBits'(1);
    localparam logic [DataLength-1:0]  BeatOne  = DataLength'(1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, END} state_t;

    state_t                 state, state_d;
    logic [AddressBits-1:0] addr_d;
    logic [DataLength-1:0]  key_d;
    logic [DataLength-1:0]  beat, beat_d;
    logic [PW-1:0]          presc, presc_d;

    // The score is only ever read; Playing and Done are pure state decodes.
    assign ReadOrWrite = 1'b1;
    assign Playing     = (state == PLAY);
    assign Done        = (state == END);

    // State, address, key and note timers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            Address <= '0;
            Key     <= '0;
            beat    <= '0;
            presc   <= '0;
        end else begin
            state   <= state_d;
            Address <= addr_d;
            Key     <= key_d;
            beat    <= beat_d;
            presc   <= presc_d;
        end
    end

    // Next-state logic: fetch/load entries, time notes, handle stop and end.
    always_comb begin
        state_d = state;
        addr_d  = Address;
        key_d   = Key;
        beat_d  = beat;
        presc_d = presc;
        if (Stop && state != IDLE) begin
            // Abort wins over everything, including a simultaneous Start.
            state_d = IDLE;
            addr_d  = '0;
            key_d   = '0;
            beat_d  = '0;
            presc_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    key_d = '0;
                    if (Start && !Stop) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end
                end
                // RAM has one cycle of latency; the address is held here.
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (ScoreKey == '0) begin
                        key_d   = '0;
                        state_d = END;
                    end else if (ScoreTime == '0) begin
                        // Zero-length entry: skip it, previous key keeps sounding.
                        addr_d  = Address + AddrOne;
                        state_d = FETCH;
                    end else begin
                        key_d   = ScoreKey;
                        beat_d  = ScoreTime;
                        presc_d = '0;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (presc == PreLast) begin
                        presc_d = '0;
                        if (beat == BeatOne) begin
                            beat_d = '0;
                            if (Address == LastAddr) begin
                                key_d   = '0;
                                state_d = END;
                            end else begin
                                // Key keeps the old note through the fetch gap.
                                addr_d  = Address + AddrOne;
                                state_d = FETCH;
                            end
                        end else begin
                            beat_d = beat - BeatOne;
                        end
                    end else begin
                        presc_d = presc + PreOne;
                    end
                end
                END: begin
                    key_d  = '0;
                    addr_d = '0;
`ifdef SCORE_LOOP_EN
                    state_d = FETCH;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: doc/music_score_player.md
MUSIC_SCORE_PLAYER -- requirements
Module: music_score_player

Interface
REQ-001 Parameter DataLength, default 4, key/time field width.
REQ-002 Parameter AddressBits, default 5, score address width.
REQ-003 Parameter MemorySize, default 20, number of score entries.
REQ-004 Parameter BeatCycles, default 25000000, Clock cycles per beat (>=2).
REQ-005 Clock  in  1  single system clock, all state on rising edge.
REQ-006 Reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-007 Start  in  1  level, sampled each cycle; begins playback from IDLE.
REQ-008 Stop  in  1  level, sampled each cycle; aborts playback.
REQ-009 ScoreKey  in  DataLength  key word returned by score RAM.
REQ-010 ScoreTime  in  DataLength  duration word (beats) returned by score RAM.
REQ-011 ReadOrWrite  out  1  score RAM mode; 1 = read.
REQ-012 Address  out  AddressBits  score RAM address.
REQ-013 Key  out  DataLength  current note to tone generator; 0 = silent.
REQ-014 Playing  out  1  high while a note sounds.
REQ-015 Done  out  1  one-cycle pulse when playback ends normally.

Function
REQ-016 The block SHALL implement FSM states IDLE, FETCH, LOAD, PLAY, END.
REQ-017 ReadOrWrite SHALL be 1 in every state and during reset; the block never writes the score.
REQ-018 Score RAM read latency SHALL be one cycle: Address driven in FETCH, ScoreKey/ScoreTime valid and sampled in LOAD.
REQ-019 IDLE: Key=0, Playing=0; Start=1 and Stop=0 -> Address<=0, go FETCH.
REQ-020 FETCH: hold Address, go LOAD next cycle.
REQ-021 LOAD, ScoreKey==0 (terminator) -> END.
REQ-022 LOAD, ScoreKey!=0 and ScoreTime==0 -> skip entry: advance Address, go FETCH, Key unchanged.
REQ-023 LOAD, ScoreKey!=0 and ScoreTime!=0 -> Key<=ScoreKey, load beat counter with ScoreTime, clear prescaler, go PLAY.
REQ-024 PLAY: Key held, Playing=1; note lasts exactly ScoreTime*BeatCycles cycles counted from first PLAY cycle.
REQ-025 PLAY expiry with Address==MemorySize-1 -> END (no terminator needed); otherwise Address<=Address+1, go FETCH.
REQ-026 Key SHALL hold the previous note through FETCH/LOAD between notes (2-cycle gap, no glitch to 0); Playing SHALL be 0 in those cycles.
REQ-027 END: Key<=0, Playing=0, Done=1 for exactly one cycle, then IDLE.
REQ-028 Stop=1 in any non-IDLE state -> next cycle IDLE, Key=0, Playing=0, Address=0, no Done pulse.
REQ-029 Stop and Start both 1 -> Stop wins.
REQ-030 Start while not IDLE SHALL be ignored.
REQ-031 Prescaler width SHALL be clog2(BeatCycles); beat counter width DataLength; no overflow permitted.

Reset
REQ-032 Reset=0 SHALL asynchronously force IDLE, Address=0, Key=0, Playing=0, Done=0, ReadOrWrite=1, counters 0.
REQ-033 Reset asserted mid-note SHALL silence Key immediately, no Done pulse; playback resumes only on a new Start.

Configuration
REQ-034 Macro SCORE_LOOP_EN: when defined, END SHALL pulse Done, then go FETCH with Address=0 (continuous repeat until Stop); when undefined, END returns to IDLE per REQ-027.

Verification (BeatCycles=4, score {1,2},{2,1},{3,1},{0,0})
REQ-035 Start pulse -> Key=1 for 8 cycles, then 2, 4 cycles, then 3, 4 cycles; Done pulse once; Key=0 after.
REQ-036 Entry {2,0} at address 1 -> note 2 skipped, Key goes 1 -> 3, Address visits 1 without Playing.
REQ-037 Stop asserted cycle 3 of note 1 -> Key=0, Address=0, IDLE next cycle, no Done.
REQ-038 Reset=0 mid-note 2 -> outputs at reset values same cycle, ReadOrWrite stays 1 throughout.
REQ-039 Full 20-entry score, no terminator -> playback ends after address 19, Done pulse.
REQ-040 SCORE_LOOP_EN defined -> after terminator, Done pulse then Key=1 replays; Stop ends loop.
